// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port between the in-order
// writeback stage and a FIFO of long-latency results (mul/div, uncached loads).
// Buffered results drain into idle writeback slots, or are forced ahead of the
// pipeline when the head has waited MAX_WAIT cycles or the pipeline targets a
// register that still has a buffered write pending.
// Optional feature macro: WB_DEBUG_TRACE_EN adds the debug_wb_* trace outputs
// and PC storage in the FIFO.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_wren_i,
    input  logic [4:0]               wb_waddr_i,
    input  logic [31:0]              wb_wdata_i,
    input  logic [31:0]              wb_pc_i,
    input  logic                     wb_flush_i,
    input  logic                     lat_valid_i,
    output logic                     lat_ready_o,
    input  logic [4:0]               lat_waddr_i,
    input  logic [31:0]              lat_wdata_i,
    input  logic [31:0]              lat_pc_i,
    output logic                     wb_stall_o,
    output logic                     rf_wren_o,
    output logic [4:0]               rf_waddr_o,
    output logic [31:0]              rf_wdata_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [3:0]    MAX_WAIT_C = 4'(MAX_WAIT);

    logic [4:0]       waddr_mem_q [DEPTH];
    logic [31:0]      wdata_mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       wait_q, wait_d;
    logic             rf_wren_q, rf_wren_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic preq, lreq, conflict, force_lat, grant_lat, grant_pipe, enq;

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] pc_mem_q [DEPTH];
    logic [31:0] dbg_pc_q, dbg_pc_d;
`endif

    // Grant decision: forced drain beats the pipeline, pipeline beats opportunistic drain.
    always_comb begin
        preq     = wb_wren_i & ~wb_flush_i & (wb_waddr_i != 5'd0);
        lreq     = (cnt_q != '0);
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (waddr_mem_q[i] == wb_waddr_i)) conflict = 1'b1;
        end
        force_lat   = lreq & ((wait_q >= MAX_WAIT_C) | (preq & conflict));
        grant_lat   = force_lat | (lreq & ~preq);
        grant_pipe  = preq & ~force_lat;
        wb_stall_o  = force_lat & preq;
        // A dequeue frees a slot this cycle, so a full FIFO can still accept.
        lat_ready_o = (cnt_q < DEPTH_C) | grant_lat;
        enq         = lat_valid_i & lat_ready_o;
    end

    // Next-state for FIFO control, wait counter and the registered write port.
    always_comb begin
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, grant_lat};
        if (grant_lat) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + 1'b1;
        end
        if (enq) begin
            vld_d[wptr_q] = 1'b1;
            wptr_d        = wptr_q + 1'b1;
        end

        wait_d = wait_q;
        if (!lreq || grant_lat)  wait_d = 4'd0;
        else if (wait_q != 4'd15) wait_d = wait_q + 4'd1;

        rf_wren_d  = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;
`ifdef WB_DEBUG_TRACE_EN
        dbg_pc_d   = 32'd0;
`endif
        if (grant_lat) begin
            // Entries targeting x0 retire without a regfile write.
            rf_wren_d  = (waddr_mem_q[rptr_q] != 5'd0);
            rf_waddr_d = waddr_mem_q[rptr_q];
            rf_wdata_d = wdata_mem_q[rptr_q];
`ifdef WB_DEBUG_TRACE_EN
            dbg_pc_d   = pc_mem_q[rptr_q];
`endif
        end else if (grant_pipe) begin
            rf_wren_d  = 1'b1;
            rf_waddr_d = wb_waddr_i;
            rf_wdata_d = wb_wdata_i;
`ifdef WB_DEBUG_TRACE_EN
            dbg_pc_d   = wb_pc_i;
`endif
        end
    end

    // Control and output state; reset discards all buffered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            wait_q     <= 4'd0;
            rf_wren_q  <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
`ifdef WB_DEBUG_TRACE_EN
            dbg_pc_q   <= 32'd0;
`endif
        end else begin
            vld_q      <= vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            rf_wren_q  <= rf_wren_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
`ifdef WB_DEBUG_TRACE_EN
            dbg_pc_q   <= dbg_pc_d;
`endif
        end
    end

    // FIFO payload storage; validity is tracked by vld_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            waddr_mem_q[wptr_q] <= lat_waddr_i;
            wdata_mem_q[wptr_q] <= lat_wdata_i;
`ifdef WB_DEBUG_TRACE_EN
            pc_mem_q[wptr_q]    <= lat_pc_i;
`endif
        end
    end

    assign rf_wren_o  = rf_wren_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign fifo_cnt_o = cnt_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = dbg_pc_q;
    assign debug_wb_rf_wen   = {4{rf_wren_q}};
    assign debug_wb_rf_wnum  = rf_waddr_q;
    assign debug_wb_rf_wdata = rf_wdata_q;
`else
    logic unused_pc;
    assign unused_pc = ^{wb_pc_i, lat_pc_i};
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sequences the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (mul/div, uncached load return) that completes out of band.
- Long-latency results are buffered in a small FIFO and drained into idle writeback slots.
- The arbiter stalls writeback when a buffered result must go first: on starvation or a register conflict.
- Sits between the writeback stage and the regfile; drives the regfile write port and the debug trace.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of 2, 2..8.
- MAX_WAIT, 4, cycles the FIFO head may wait before it is forced through; 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_wren_i  in  1  pipeline write request
- wb_waddr_i  in  5  pipeline destination register
- wb_wdata_i  in  32  pipeline write data
- wb_pc_i  in  32  pipeline instruction PC
- wb_flush_i  in  1  kill the pipeline request this cycle
- lat_valid_i  in  1  long-latency result valid
- lat_ready_o  out  1  FIFO can accept a result
- lat_waddr_i  in  5  long-latency destination register
- lat_wdata_i  in  32  long-latency data
- lat_pc_i  in  32  long-latency instruction PC
- wb_stall_o  out  1  hold the writeback stage; pipeline request not consumed
- rf_wren_o  out  1  regfile write enable
- rf_waddr_o  out  5  regfile write address
- rf_wdata_o  out  32  regfile write data
- fifo_cnt_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - rf_wren_o, rf_waddr_o, rf_wdata_o = 0.
  - FIFO empty, fifo_cnt_o = 0.
  - Wait counter = 0.
  - lat_ready_o = 1 and wb_stall_o = 0 after reset.
  - Reset mid-operation discards all buffered results.
- Effective pipeline request: preq = wb_wren_i & ~wb_flush_i & (wb_waddr_i != 0).
- Effective long-latency request: lreq = FIFO non-empty.
- FIFO enqueue:
  - Enqueue when lat_valid_i & lat_ready_o.
  - lat_ready_o = (cnt < DEPTH) combinationally.
  - lat_ready_o stays 1 when full and dequeuing in the same cycle.
  - Entries with waddr 0 are accepted and retired without a regfile write.
- Combinational grant, evaluated in priority order:
  - 1. force_lat = lreq & (waitcnt >= MAX_WAIT or wb_waddr_i matches the waddr of any valid FIFO entry while preq). Grant the FIFO head; wb_stall_o = preq.
  - 2. Else if preq: grant the pipeline; wb_stall_o = 0.
  - 3. Else if lreq: grant the FIFO head.
  - 4. Else: idle.
- Write port output:
  - Registered; granted write appears on rf_* the cycle after the grant (1-cycle latency).
  - rf_wren_o = 0 on idle or when the granted entry has waddr 0.
- Wait counter:
  - Increments each cycle lreq is high and the head is not granted, saturating at 15.
  - Clears on head dequeue or when the FIFO is empty.
- Simultaneous enqueue and dequeue: count unchanged, pointers advance and wrap modulo DEPTH.
- Enqueue into an empty FIFO: the entry is not grantable until the next cycle (no bypass).
- Flush: drops only the pipeline request. It never clears the FIFO, and wb_stall_o is 0 for a flushed request.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0].
  - Registered alongside rf_*.
  - debug_wb_rf_wen = {4{rf_wren_o}}.
  - debug_wb_pc carries the PC of the granted source (pipeline or FIFO head).
- Undefined: ports and PC storage in the FIFO are absent; functional write behaviour is identical.

Test Plan:
- Pipeline only: wb_wren_i=1, waddr=5, wdata=0x1234 for 3 cycles, FIFO empty -> rf_wren_o=1, waddr 5, data 0x1234 one cycle later each cycle; wb_stall_o=0.
- Idle drain: lat_valid_i with waddr 7, data 0xAA, pipeline idle -> rf_* = (1, 7, 0xAA) two cycles after enqueue; fifo_cnt_o returns to 0.
- Starvation: FIFO holds one entry and the pipeline writes every cycle, MAX_WAIT=4 -> wb_stall_o=1 in the fifth cycle; FIFO entry written; pipeline write follows the next cycle.
- Conflict: FIFO holds waddr 9 = 0x11; pipeline requests waddr 9 = 0x22 -> stall; rf writes 0x11 then 0x22 in order.
- Full/flush: enqueue DEPTH=4 entries with the pipeline busy -> lat_ready_o=0 at cnt=4. Assert wb_flush_i -> no stall; head drains; lat_ready_o=1 the same cycle the head is dequeued.
- Reset mid-operation: rst_n low with cnt=3 -> rf_wren_o=0 immediately; cnt=0; no buffered writes appear after release.
